serial_add_ctrl: RTL
====================

// Module: serial_add_ctrl
// PURPOSE
//  Bit-serial adder controller. Time-shares one fulladder instance across a
//  WIDTH-bit addition, one bit per clock, LSB first.
//  Sequences operand shift registers and a carry flip-flop, and signals
//  completion with a START/BUSY/DONE handshake.
//  Sits beside the fulladder in area-constrained datapaths in place of a
//  WIDTH-wide ripple adder.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range 1..64
// PORTS
//  CLK    in   1       rising-edge clock, single clock domain
//  RST    in   1       synchronous active-high reset
//  START  in   1       request; sampled only in IDLE
//  A      in   WIDTH   operand A, captured on the accepted START edge
//  B      in   WIDTH   operand B, captured on the accepted START edge
//  Cin    in   1       carry-in, captured on the accepted START edge
//  BUSY   out  1       high while in RUN
//  DONE   out  1       one-cycle pulse; result valid
//  SUM    out  WIDTH   registered result; held until the next result load
//  Cout   out  1       registered final carry; held with SUM
// BEHAVIOUR
//  Reset: synchronous, active-high, applied on a rising CLK edge with RST=1.
//   Values after the reset edge:
//   - state=IDLE, BUSY=0, DONE=0, SUM=0, Cout=0.
//   - shift registers, carry FF and bit counter cleared.
//   - RST has priority over every other event, including mid-RUN.
//     The operation in flight is discarded and DONE is not pulsed.
//  FSM states: IDLE, RUN, FIN.
//  - IDLE: on an edge with START=1:
//    - load a_sr<=A, b_sr<=B, c_ff<=Cin, cnt<=0.
//    - go to RUN.
//    With START=0, remain in IDLE.
//  - RUN: the fulladder inputs are a_sr[0], b_sr[0] and c_ff. On each edge:
//    - a_sr and b_sr shift right by 1.
//    - the fulladder OUT enters s_sr at the MSB; s_sr shifts right.
//    - c_ff <= fulladder Cout; cnt <= cnt+1.
//    On the edge where cnt==WIDTH-1:
//    - SUM <= final s_sr value (including this bit).
//    - Cout <= fulladder Cout.
//    - go to FIN.
//  - FIN: DONE=1 for exactly this cycle; go to IDLE on the next edge.
//    START is ignored in FIN.
//  Latency: START is accepted at edge k. RUN covers edges k+1..k+WIDTH.
//   DONE is high in the cycle after edge k+WIDTH. Next START acceptance is at
//   edge k+WIDTH+2 at the earliest.
//   Throughput: 1 add per WIDTH+2 cycles.
//  START asserted in RUN or FIN is ignored, not queued. A, B and Cin are
//   don't-care outside the accepting edge.
//  SUM and Cout change only on the last RUN edge (and on reset), so they are
//   never partial results. The previous result stays visible during a new RUN.
//  Arithmetic: {Cout,SUM} = A + B + Cin modulo 2^(WIDTH+1), unsigned.
//  Counter width: $clog2(WIDTH), minimum 1 bit. For WIDTH=1, RUN lasts exactly
//   one cycle.
//  BUSY and DONE are registered/state-decoded, with no combinational path from
//   the inputs.
// TESTING
//  T1 WIDTH=8: A=8'h05, B=8'h03, Cin=0, START pulse.
//     Required: BUSY high 8 cycles; DONE pulses on cycle 9; SUM=8'h08, Cout=0.
//  T2 A=8'hFF, B=8'h01, Cin=0.
//     Required: SUM=8'h00, Cout=1.
//  T3 A=8'hFF, B=8'hFF, Cin=1.
//     Required: SUM=8'hFF, Cout=1.
//  T4 START held high continuously with operands changed mid-RUN.
//     Required: only the operands captured at acceptance are used. Results are
//     back to back every 10 cycles; exactly one DONE per operation.
//  T5 RST=1 in the 4th RUN cycle.
//     Required: next cycle IDLE, BUSY=0, SUM=0, Cout=0, and no DONE. A fresh
//     START 8'h10+8'h20 then gives SUM=8'h30.
//  T6 WIDTH=1: A=1, B=1, Cin=1.
//     Required: DONE 2 cycles after START; SUM=1, Cout=1.
//     Then random compare versus A+B+Cin, 1000 vectors, WIDTH=8 and WIDTH=13.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder, one full-adder slice reused each clock, LSB first
// Ports:
//   CLK, RST   rising-edge clock, synchronous active-high reset
//   START      request, honoured only while idle
//   A, B, Cin  operands, captured on the edge that accepts START
//   BUSY       high while bits are being added
//   DONE       one-cycle pulse when SUM/Cout have just been updated
//   SUM, Cout  registered result, held until the next completion
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             Cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2;
    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_next;
    logic             c_ff;
    logic [CW-1:0]    cnt;
    logic             fa_s, fa_c;
    assign fa_s = a_sr[0] ^ b_sr[0] ^ c_ff;
    assign fa_c = (a_sr[0] & b_sr[0]) | (c_ff & (a_sr[0] ^ b_sr[0]));
    // each new bit enters at the MSB, so after WIDTH shifts the first bit sits at bit 0
    assign s_next = WIDTH'({fa_s, s_sr} >> 1);
    assign BUSY = state == RUN;
    assign DONE = state == FIN;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            c_ff  <= 1'b0;
            cnt   <= '0;
            SUM   <= '0;
            Cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (START) begin
                    a_sr  <= A;
                    b_sr  <= B;
                    c_ff  <= Cin;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    s_sr <= s_next;
                    c_ff <= fa_c;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        SUM   <= s_next;
                        Cout  <= fa_c;
                        state <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
